cdb_arbiter: RTL and testbench

Snooping-bus arbiter and transaction sequencer sitting directly downstream of the processor cores. Each core raises a bus request carrying a 22-bit Common Data Bus (CDB) word. The block grants the bus round-robin, broadcasts the winner's word to all snoopers and collects their hit/dirty responses. It then completes the transaction against memory (read, write or dirty-owner flush) and returns data plus a one-cycle Done to the requester.

---
 rtl/cdb_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Snooping-bus arbiter: round-robin grant of the CDB, snoop collection, and
// memory completion (read, write or dirty-owner flush) with a Done pulse back to the winner.
module cdb_arbiter #(
  parameter int NCORES        = 4,
  parameter int SNOOP_TIMEOUT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCORES-1:0]      req_i,
  input  logic [22*NCORES-1:0]   req_cdb_i,
  output logic [NCORES-1:0]      grant_o,
  output logic [21:0]            cdb_o,
  output logic                   cdb_valid_o,
  input  logic [NCORES-1:0]      snoop_ack_i,
  input  logic [NCORES-1:0]      snoop_hit_i,
  input  logic [NCORES-1:0]      snoop_dirty_i,
  input  logic [16*NCORES-1:0]   snoop_data_i,
  output logic                   mem_rd_o,
  output logic                   mem_wr_o,
  output logic [3:0]             mem_addr_o,
  output logic [15:0]            mem_wdata_o,
  input  logic                   mem_ack_i,
  input  logic [15:0]            mem_rdata_i,
  output logic [NCORES-1:0]      done_o,
  output logic [15:0]            resp_data_o,
  output logic                   resp_shared_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_BCAST, S_SNOOP, S_FLUSH, S_MEMRD, S_MEMWR, S_DONE
  } state_t;

  state_t              state_q;
  logic [NCORES-1:0]   grant_q, done_q;
  logic [NCORES-1:0]   ack_acc_q, hit_acc_q, dirty_acc_q;
  logic [21:0]         cdb_q;
  logic                cdb_valid_q, mem_rd_q, mem_wr_q, resp_shared_q;
  logic [3:0]          mem_addr_q;
  logic [15:0]         mem_wdata_q, resp_data_q, owner_data_q;
  logic [1:0]          rr_ptr_q, win_q, owner_q;
  logic [7:0]          snoop_cnt_q;

  logic                win_found_s;
  logic [1:0]          win_id_s;
  logic [NCORES-1:0]   win_onehot_s;
  logic [21:0]         win_cdb_s;
  int                  idx_s;

  logic [NCORES-1:0]   ack_now_s, dirty_now_s, ack_all_s, hit_all_s, dirty_all_s;
  logic                snoop_done_s, new_dirty_s, owner_take_s;
  logic [1:0]          new_owner_s, owner_d;
  logic [15:0]         new_owner_data_s, owner_data_d;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found_s  = 1'b0;
    win_id_s     = 2'd0;
    win_onehot_s = '0;
    win_cdb_s    = 22'd0;
    idx_s        = 0;
    for (int k = 0; k < NCORES; k++) begin
      idx_s = (int'(rr_ptr_q) + k) % NCORES;
      if (!win_found_s && req_i[idx_s]) begin
        win_found_s         = 1'b1;
        win_id_s            = 2'(idx_s);
        win_onehot_s[idx_s] = 1'b1;
        win_cdb_s           = req_cdb_i[22*idx_s +: 22];
      end
    end
  end

  // Snoop accumulation; the winner's own lines are masked out, and hit/dirty only count with an ack.
  always_comb begin
    ack_now_s        = snoop_ack_i & ~grant_q;
    dirty_now_s      = snoop_dirty_i & ack_now_s;
    ack_all_s        = ack_acc_q | ack_now_s;
    hit_all_s        = hit_acc_q | (snoop_hit_i & ack_now_s);
    dirty_all_s      = dirty_acc_q | dirty_now_s;
    snoop_done_s     = ((ack_all_s | grant_q) == {NCORES{1'b1}}) ||
                       (snoop_cnt_q == 8'(SNOOP_TIMEOUT));
    new_dirty_s      = 1'b0;
    new_owner_s      = 2'd0;
    new_owner_data_s = 16'd0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (dirty_now_s[i]) begin
        new_dirty_s      = 1'b1;
        new_owner_s      = 2'(i);
        new_owner_data_s = snoop_data_i[16*i +: 16];
      end
    end
    // Owner data is captured when the ack arrives, so a later drop of SnoopData is harmless.
    owner_take_s = new_dirty_s && ((dirty_acc_q == '0) || (new_owner_s < owner_q));
    if (owner_take_s) begin
      owner_d      = new_owner_s;
      owner_data_d = new_owner_data_s;
    end else begin
      owner_d      = owner_q;
      owner_data_d = owner_data_q;
    end
  end

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      done_q        <= '0;
      ack_acc_q     <= '0;
      hit_acc_q     <= '0;
      dirty_acc_q   <= '0;
      cdb_q         <= 22'd0;
      cdb_valid_q   <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= 4'd0;
      mem_wdata_q   <= 16'd0;
      resp_data_q   <= 16'd0;
      resp_shared_q <= 1'b0;
      owner_data_q  <= 16'd0;
      rr_ptr_q      <= 2'd0;
      win_q         <= 2'd0;
      owner_q       <= 2'd0;
      snoop_cnt_q   <= 8'd0;
    end else begin
      cdb_valid_q <= 1'b0;
      done_q      <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found_s) begin
            grant_q      <= win_onehot_s;
            cdb_q        <= win_cdb_s;
            cdb_valid_q  <= 1'b1;
            win_q        <= win_id_s;
            ack_acc_q    <= '0;
            hit_acc_q    <= '0;
            dirty_acc_q  <= '0;
            owner_q      <= 2'd0;
            owner_data_q <= 16'd0;
            state_q      <= S_BCAST;
          end
        end
        S_BCAST: begin
          if (cdb_q[21:20] == 2'b01 || cdb_q[21:20] == 2'b10) begin
            snoop_cnt_q <= 8'd1;
            state_q     <= S_SNOOP;
          end else begin
            resp_data_q   <= 16'd0;
            resp_shared_q <= 1'b0;
            done_q        <= grant_q;
            state_q       <= S_DONE;
          end
        end
        S_SNOOP: begin
          ack_acc_q    <= ack_all_s;
          hit_acc_q    <= hit_all_s;
          dirty_acc_q  <= dirty_all_s;
          owner_q      <= owner_d;
          owner_data_q <= owner_data_d;
          if (snoop_done_s) begin
            mem_addr_q <= cdb_q[19:16];
            if (cdb_q[21:20] == 2'b10) begin
              mem_wr_q      <= 1'b1;
              mem_wdata_q   <= cdb_q[15:0];
              resp_data_q   <= cdb_q[15:0];
              resp_shared_q <= 1'b0;
              state_q       <= S_MEMWR;
            end else if (dirty_all_s != '0) begin
              cdb_q         <= {2'b11, cdb_q[19:16], owner_data_d};
              cdb_valid_q   <= 1'b1;
              mem_wr_q      <= 1'b1;
              mem_wdata_q   <= owner_data_d;
              resp_data_q   <= owner_data_d;
              resp_shared_q <= 1'b1;
              state_q       <= S_FLUSH;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= S_MEMRD;
            end
          end else begin
            snoop_cnt_q <= snoop_cnt_q + 8'd1;
          end
        end
        S_FLUSH, S_MEMWR: begin
          if (mem_ack_i) begin
            mem_wr_q <= 1'b0;
            done_q   <= grant_q;
            state_q  <= S_DONE;
          end
        end
        S_MEMRD: begin
          if (mem_ack_i) begin
            mem_rd_q      <= 1'b0;
            resp_data_q   <= mem_rdata_i;
            resp_shared_q <= |hit_acc_q;
            done_q        <= grant_q;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          grant_q  <= '0;
          rr_ptr_q <= (win_q == 2'(NCORES - 1)) ? 2'd0 : win_q + 2'd1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign cdb_o         = cdb_q;
  assign cdb_valid_o   = cdb_valid_q;
  assign mem_rd_o      = mem_rd_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign done_o        = done_q;
  assign resp_data_o   = resp_data_q;
  assign resp_shared_o = resp_shared_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of single transactions plus hand-written
// reset, round-robin and snoop-timeout sequences.
module tb_cdb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [87:0] req_cdb_i;
  logic [3:0]  grant_o;
  logic [21:0] cdb_o;
  logic        cdb_valid_o;
  logic [3:0]  snoop_ack_i, snoop_hit_i, snoop_dirty_i;
  logic [63:0] snoop_data_i;
  logic        mem_rd_o, mem_wr_o;
  logic [3:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [15:0] mem_rdata_i;
  logic [3:0]  done_o;
  logic [15:0] resp_data_o;
  logic        resp_shared_o;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NCORES(4), .SNOOP_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_cdb_i(req_cdb_i),
    .grant_o(grant_o), .cdb_o(cdb_o), .cdb_valid_o(cdb_valid_o),
    .snoop_ack_i(snoop_ack_i), .snoop_hit_i(snoop_hit_i),
    .snoop_dirty_i(snoop_dirty_i), .snoop_data_i(snoop_data_i),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .done_o(done_o), .resp_data_o(resp_data_o), .resp_shared_o(resp_shared_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          core;
    logic [21:0] cdb;
    logic [3:0]  ack, hit, dirty;
    logic [63:0] sdata;
    logic [15:0] rdata;
    bit          exp_rd, exp_wr;
    logic [3:0]  exp_addr;
    logic [15:0] exp_wdata;
    bit          exp_flush;
    logic [21:0] exp_flush_cdb;
    logic [15:0] exp_resp;
    bit          exp_shared;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int core, input logic [21:0] cdb,
                              input logic [3:0] ack, input logic [3:0] hit,
                              input logic [3:0] dirty, input logic [63:0] sdata,
                              input logic [15:0] rdata, input bit erd, input bit ewr,
                              input logic [3:0] eaddr, input logic [15:0] ewdata,
                              input bit eflush, input logic [21:0] eflush_cdb,
                              input logic [15:0] eresp, input bit eshared, input int ecyc);
    vec_t v;
    v.core = core; v.cdb = cdb; v.ack = ack; v.hit = hit; v.dirty = dirty;
    v.sdata = sdata; v.rdata = rdata; v.exp_rd = erd; v.exp_wr = ewr;
    v.exp_addr = eaddr; v.exp_wdata = ewdata; v.exp_flush = eflush;
    v.exp_flush_cdb = eflush_cdb; v.exp_resp = eresp; v.exp_shared = eshared;
    v.exp_cycles = ecyc;
    return v;
  endfunction

  // Runs one transaction from the grant edge to the cycle after Done.
  task automatic run_txn(input vec_t v, input bit drive_req);
    int cycles, flushes;
    bit seen_rd, seen_wr, acked, got_done;
    logic [3:0]  seen_addr;
    logic [15:0] seen_wdata;
    logic [3:0]  onehot;
    onehot = 4'd0;
    onehot[v.core] = 1'b1;
    snoop_ack_i = v.ack; snoop_hit_i = v.hit; snoop_dirty_i = v.dirty;
    snoop_data_i = v.sdata;
    if (drive_req) begin
      req_i = onehot;
      req_cdb_i = 88'd0;
      req_cdb_i[22*v.core +: 22] = v.cdb;
    end
    @(posedge clk_i); #1;
    check("grant", {28'd0, grant_o}, {28'd0, onehot});
    check("bcast_valid", {31'd0, cdb_valid_o}, 32'd1);
    check("bcast_cdb", {10'd0, cdb_o}, {10'd0, v.cdb});
    if (drive_req) req_i = 4'd0;
    cycles = 0; flushes = 0; seen_rd = 0; seen_wr = 0; acked = 0; got_done = 0;
    seen_addr = 4'd0; seen_wdata = 16'd0;
    while (!got_done && cycles < 40) begin
      @(posedge clk_i); #1;
      cycles++;
      mem_ack_i = 1'b0;
      check("grant_onehot", {31'd0, $onehot0(grant_o)}, 32'd1);
      if (cdb_valid_o) begin
        flushes++;
        check("flush_cdb", {10'd0, cdb_o}, {10'd0, v.exp_flush_cdb});
      end
      if ((mem_rd_o || mem_wr_o) && !acked) begin
        seen_rd = mem_rd_o; seen_wr = mem_wr_o;
        seen_addr = mem_addr_o; seen_wdata = mem_wdata_o;
        mem_ack_i = 1'b1; mem_rdata_i = v.rdata; acked = 1;
      end
      if (done_o != 4'd0) got_done = 1;
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("latency", cycles, v.exp_cycles);
    check("done", {28'd0, done_o}, {28'd0, onehot});
    check("mem_rd_seen", {31'd0, seen_rd}, {31'd0, v.exp_rd});
    check("mem_wr_seen", {31'd0, seen_wr}, {31'd0, v.exp_wr});
    if (v.exp_rd || v.exp_wr) check("mem_addr", {28'd0, seen_addr}, {28'd0, v.exp_addr});
    if (v.exp_wr) check("mem_wdata", {16'd0, seen_wdata}, {16'd0, v.exp_wdata});
    check("flush_count", flushes, v.exp_flush ? 1 : 0);
    check("resp_data", {16'd0, resp_data_o}, {16'd0, v.exp_resp});
    check("resp_shared", {31'd0, resp_shared_o}, {31'd0, v.exp_shared});
    @(posedge clk_i); #1;
    check("done_one_cycle", {28'd0, done_o}, 32'd0);
    check("grant_dropped", {28'd0, grant_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int n;
    // core, cdb, ack, hit, dirty, sdata, rdata, rd, wr, addr, wdata, flush, flush_cdb, resp, shared, cycles
    vecs[0] = mk(1, 22'h15ABCD, 4'b1101, 4'b0000, 4'b0000, 64'd0, 16'h1234,
                 1, 0, 4'h5, 16'h0, 0, 22'h0, 16'h1234, 0, 3);
    vecs[1] = mk(0, 22'h130000, 4'b1110, 4'b0100, 4'b0100, {16'h0, 16'hBEEF, 32'h0}, 16'h0,
                 0, 1, 4'h3, 16'hBEEF, 1, 22'h33BEEF, 16'hBEEF, 1, 3);
    vecs[2] = mk(3, 22'h2900FF, 4'b0111, 4'b0010, 4'b0000, 64'd0, 16'h0,
                 0, 1, 4'h9, 16'h00FF, 0, 22'h0, 16'h00FF, 0, 3);
    vecs[3] = mk(2, 22'h1A0000, 4'b1011, 4'b1001, 4'b0000, 64'd0, 16'h5555,
                 1, 0, 4'hA, 16'h0, 0, 22'h0, 16'h5555, 1, 3);
    vecs[4] = mk(3, 22'h170000, 4'b0111, 4'b0110, 4'b0110, {16'h0, 16'h2222, 16'h1111, 16'h0}, 16'h0,
                 0, 1, 4'h7, 16'h1111, 1, 22'h371111, 16'h1111, 1, 3);
    vecs[5] = mk(0, 22'h120000, 4'b1111, 4'b0001, 4'b0001, {48'h0, 16'hDEAD}, 16'h0F0F,
                 1, 0, 4'h2, 16'h0, 0, 22'h0, 16'h0F0F, 0, 3);
    vecs[6] = mk(1, 22'h04AAAA, 4'b1111, 4'b0000, 4'b0000, 64'd0, 16'h0,
                 0, 0, 4'h0, 16'h0, 0, 22'h0, 16'h0000, 0, 1);
    vecs[7] = mk(2, 22'h3BCCCC, 4'b1111, 4'b0000, 4'b0000, 64'd0, 16'h0,
                 0, 0, 4'h0, 16'h0, 0, 22'h0, 16'h0000, 0, 1);

    rst_i = 1'b1; req_i = 4'd0; req_cdb_i = 88'd0;
    snoop_ack_i = 4'd0; snoop_hit_i = 4'd0; snoop_dirty_i = 4'd0; snoop_data_i = 64'd0;
    mem_ack_i = 1'b0; mem_rdata_i = 16'd0;
    #2;
    check("rst_grant", {28'd0, grant_o}, 32'd0);
    check("rst_cdb", {10'd0, cdb_o}, 32'd0);
    check("rst_strobes", {29'd0, cdb_valid_o, mem_rd_o, mem_wr_o}, 32'd0);
    check("rst_done", {28'd0, done_o}, 32'd0);
    check("rst_resp", {15'd0, resp_shared_o, resp_data_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], 1'b1);

    // Reset in the middle of MEMRD aborts asynchronously.
    snoop_ack_i = 4'b1101; snoop_hit_i = 4'd0; snoop_dirty_i = 4'd0;
    req_i = 4'b0010; req_cdb_i = 88'd0; req_cdb_i[22 +: 22] = 22'h150000;
    @(posedge clk_i); #1;
    check("rstmid_grant", {28'd0, grant_o}, 32'h2);
    req_i = 4'd0;
    n = 0;
    while (!mem_rd_o && n < 10) begin @(posedge clk_i); #1; n++; end
    check("rstmid_memrd", {31'd0, mem_rd_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rstmid_async", {3'd0, mem_rd_o, grant_o, cdb_valid_o, cdb_o}, 32'd0);
    @(posedge clk_i); #1;
    check("rstmid_no_done", {28'd0, done_o}, 32'd0);
    @(negedge clk_i); rst_i = 1'b0;

    // Round robin with all four requesting: order 0,1,2,3,0.
    req_i = 4'b1111;
    for (int c = 0; c < 4; c++) req_cdb_i[22*c +: 22] = {2'b01, 4'(c), 16'h0000};
    for (int i = 0; i < 5; i++) begin
      v = mk(i % 4, {2'b01, 4'(i % 4), 16'h0000}, 4'b1111, 4'b0000, 4'b0000, 64'd0,
             16'hA000 + 16'(i), 1, 0, 4'(i % 4), 16'h0, 0, 22'h0, 16'hA000 + 16'(i), 0, 3);
      run_txn(v, 1'b0);
    end
    req_i = 4'd0;
    @(posedge clk_i); #1;

    // Snoop timeout: core 2 never acks; its hit/dirty must be ignored.
    snoop_ack_i = 4'b1010; snoop_hit_i = 4'b0100; snoop_dirty_i = 4'b0100;
    snoop_data_i = {16'h0, 16'h9999, 32'h0};
    req_i = 4'b0001; req_cdb_i = 88'd0; req_cdb_i[21:0] = 22'h160000;
    @(posedge clk_i); #1;
    check("to_grant", {28'd0, grant_o}, 32'h1);
    req_i = 4'd0;
    n = 0;
    while (!mem_rd_o && !mem_wr_o && n < 20) begin @(posedge clk_i); #1; n++; end
    check("to_snoop_cycles", n, 9);
    check("to_is_read", {30'd0, mem_rd_o, mem_wr_o}, 32'h2);
    check("to_addr", {28'd0, mem_addr_o}, 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("to_memrd_held", {31'd0, mem_rd_o}, 32'd1);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 16'h7777;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    check("to_memrd_cleared", {31'd0, mem_rd_o}, 32'd0);
    check("to_done", {28'd0, done_o}, 32'h1);
    check("to_resp", {15'd0, resp_shared_o, resp_data_o}, 32'h0_7777);
    @(posedge clk_i); #1;
    check("to_done_drop", {28'd0, done_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
